// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte out on device clock, check ACK.
// Optional build macro PS2_TX_RETRY_EN: one automatic retry of a no-ACK failure per accepted byte.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_ABORT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_NOACK   = 2'd2
  } err_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            nbit_q, nbit_d;
  logic [9:0]            frame_q, frame_d;
  logic [9:0]            shift_q, shift_d;
  logic                  data_oe_d, tx_done_d, tx_err_d;
  logic [1:0]            err_code_d;
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt, clk_filt_d1;
  logic                  fall, data_s, timeout;
`ifdef PS2_TX_RETRY_EN
  logic                  retried_q, retried_d;
`endif

  // Pin conditioning: the clock level only changes after FILTER_LEN identical synchronized samples.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register updates from pre-edge values.
    if (rst) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      clk_hist    <= '1;
      clk_filt    <= 1'b1;
      clk_filt_d1 <= 1'b1;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk_in};
      data_sync   <= {data_sync[0], ps2_data_in};
      clk_hist    <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&clk_hist)       clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      clk_filt_d1 <= clk_filt;
    end
  end

  assign fall    = clk_filt_d1 & ~clk_filt;
  assign data_s  = data_sync[1];
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    state_d    = state_q;
    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    nbit_d     = nbit_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    data_oe_d  = ps2_data_oe;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    err_code_d = err_code;
`ifdef PS2_TX_RETRY_EN
    retried_d  = retried_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          state_d    = S_INHIBIT;
          frame_d    = {1'b1, ~^tx_data, tx_data};
          err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
          retried_d  = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        data_oe_d = 1'b0;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          nbit_d    = '0;
          shift_d   = frame_q;
          data_oe_d = 1'b1;
        end
      end
      S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE: begin
        if (fall) cnt_d = '0;
        if (state_q == S_WAIT_IDLE && clk_filt && data_s) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end else if (fall && state_q == S_ACK) begin
          if (!data_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            state_d = S_ABORT;
`ifdef PS2_TX_RETRY_EN
            if (!retried_q) begin
              retried_d = 1'b1;
            end else begin
              tx_err_d   = 1'b1;
              err_code_d = ERR_NOACK;
            end
`else
            tx_err_d   = 1'b1;
            err_code_d = ERR_NOACK;
`endif
          end
        end else if (fall && state_q != S_WAIT_IDLE) begin
          // Start bit is already on the line; falls 1..10 present data, parity, then the stop bit.
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          nbit_d    = nbit_q + 4'd1;
          state_d   = (nbit_q == 4'd9) ? S_ACK : S_SHIFT;
        end else if (timeout && !fall) begin
          state_d    = S_ABORT;
          data_oe_d  = 1'b0;
          tx_err_d   = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_ABORT: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
        // An ABORT without the error pulse is the single retry of a no-ACK failure.
        if (!tx_err) state_d = S_INHIBIT;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nbit_q      <= '0;
      frame_q     <= '0;
      shift_q     <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= ERR_NONE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbit_q      <= nbit_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      tx_ready    <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      tx_done     <= tx_done_d;
      tx_err      <= tx_err_d;
      err_code    <= err_code_d;
      ps2_clk_oe  <= (state_d == S_INHIBIT);
      ps2_data_oe <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
      retried_q   <= retried_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a behavioural PS/2 device clocks frames out of the host and ACKs or refuses.
module tb_ps2_tx;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 3000;
  localparam int H       = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0;
  logic clk_oe_prev = 1'b0;

  // Open-drain bus: the line is low if anybody pulls it.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    if (ps2_clk_oe === 1'b1 && !clk_oe_prev) inh_cnt++;
    clk_oe_prev = (ps2_clk_oe === 1'b1);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts inhibit cycles and stops on the first cycle the request (data low, clock released) is seen.
  task automatic measure_req(output int len, output bit ok, output int t0);
    len = 0; ok = 1'b0; t0 = 0;
    for (int i = 0; i < 3 * INHIBIT && !ok; i++) begin
      if (ps2_clk_oe) len++;
      else if (ps2_data_oe) begin ok = 1'b1; t0 = cyc; end
      if (!ok) @(negedge clk);
    end
  endtask

  // Device model: samples the line at the end of each high phase (the rising-edge sample), then pulls clock low.
  task automatic device_frame(input int stop_at, input bit ack, input int glitch_k,
                              output logic [10:0] bits, output bit ok);
    bits = '0; ok = 1'b0;
    for (int i = 0; i < 3 * INHIBIT && !ok; i++) begin
      if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) return;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      bits[k-1] = ps2_data_in;
      if (k == 11 && ack) begin dev_data_low = 1'b1; repeat (4) @(negedge clk); end
      dev_clk_low = 1'b1;
      if (k == stop_at) begin repeat (12) @(negedge clk); dev_clk_low = 1'b0; return; end
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k == glitch_k) begin
        repeat (8) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (H - 11) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int len, t0, d0, e0, i0;
    bit seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_code", err_code, 0);

    // 0xED with ACK: frame start,1,0,1,1,0,1,1,1,parity 1,stop 1.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    measure_req(len, ok, t0);
    check("ed_inhibit_len", len, INHIBIT);
    check("ed_req_seen", ok, 1);
    check("ed_req_data_oe", ps2_data_oe, 1);
    check("ed_req_clk_oe", ps2_clk_oe, 0);
    device_frame(0, 1'b1, 0, bits, ok);
    check("ed_bits", bits, 11'h7DA);
    wait_ready(ok);
    check("ed_ready", ok, 1);
    check("ed_done", done_cnt - d0, 1);
    check("ed_err", err_cnt - e0, 0);
    check("ed_code", err_code, 0);

    // 0xFF refused at edge 11.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    measure_req(len, ok, t0);
    check("na_req_seen", ok, 1);
`ifdef PS2_TX_RETRY_EN
    device_frame(0, 1'b0, 0, bits, ok);
    check("na_bits_first", bits, 11'h7FE);
    repeat (20) @(negedge clk);
    check("na_no_err_first", err_cnt - e0, 0);
    check("na_reinhibit", ps2_clk_oe, 1);
    measure_req(len, ok, t0);
    check("na_retry_req", ok, 1);
`endif
    device_frame(0, 1'b0, 0, bits, ok);
    check("na_bits", bits, 11'h7FE);
    wait_ready(ok);
    check("na_ready", ok, 1);
    check("na_err", err_cnt - e0, 1);
    check("na_done", done_cnt - d0, 0);
    check("na_code", err_code, 2);
    check("na_clk_oe", ps2_clk_oe, 0);
    check("na_data_oe", ps2_data_oe, 0);

    // Silent device: error exactly TIMEOUT cycles after entering REQ.
    send(8'h12);
    measure_req(len, ok, t0);
    check("to_req_seen", ok, 1);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_err) seen = 1'b1;
    end
    check("to_seen", seen, 1);
    check("to_cycles", cyc - t0, TIMEOUT);
    check("to_code", err_code, 1);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    wait_ready(ok);

    // Reset at fall 5 of a 0xFF send.
    send(8'hFF);
    measure_req(len, ok, t0);
    device_frame(5, 1'b1, 0, bits, ok);
    check("rs_busy_before", busy, 1);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rs_clk_oe", ps2_clk_oe, 0);
    check("rs_data_oe", ps2_data_oe, 0);
    check("rs_ready", tx_ready, 1);
    check("rs_busy", busy, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rs_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // 0xF4 afterwards completes normally (parity 0).
    d0 = done_cnt;
    send(8'hF4);
    measure_req(len, ok, t0);
    device_frame(0, 1'b1, 0, bits, ok);
    check("f4_bits", bits, 11'h5E8);
    wait_ready(ok);
    check("f4_done", done_cnt - d0, 1);
    check("f4_code", err_code, 0);

    // 0xAA with a clock glitch and a tx_valid pulse while busy.
    d0 = done_cnt; i0 = inh_cnt;
    send(8'hAA);
    measure_req(len, ok, t0);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device_frame(0, 1'b1, 4, bits, ok);
    check("gl_bits", bits, 11'h754);
    wait_ready(ok);
    repeat (200) @(negedge clk);
    check("gl_done", done_cnt - d0, 1);
    check("gl_one_frame", inh_cnt - i0, 1);
    check("done_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
